neural_unit_seq: RTL and testbench

- Parametrised successor to the fixed 4-input neural unit.
- Holds N_INPUTS signed weights in a register file and computes the weighted sum of N_INPUTS signed fixed-point inputs, using one time-shared multiply-accumulate step per cycle.
- Saturates the sum and, for hidden layers, applies the Elliot activation y = x/(1+|x|) through an iterative divider.
- Sits between layer input registers and the layer sequencer, which waits on layerDone.

---
 rtl/neural_unit_seq.sv | 177 +++++++++++++++++
 tb/tb_neural_unit_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/neural_unit_seq.sv
// Sequential neural unit: a time-shared multiply-accumulate over N_INPUTS weighted inputs,
// symmetric saturation, and an optional Elliot activation x/(1+|x|) computed by restoring division.
module neural_unit_seq #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ADDR_W   = $clog2(N_INPUTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_INPUTS*DATA_W-1:0]   inputs,
  input  logic [WEIGHT_W-1:0]          weight,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         write,
  input  logic                         sumTrigger,
  input  logic                         layer_Sel,
  output logic [DATA_W-1:0]            layerOut,
  output logic                         layerDone,
  output logic                         busy
);

  // state  | meaning
  // S_IDLE | accept weight writes and start pulses
  // S_MAC  | one product per cycle; the product is registered, so one flush cycle follows the last index
  // S_SAT  | clamp accumulator; linear result is written here, otherwise set up the divider
  // S_ACT  | restoring division, one quotient bit per cycle
  // S_DONE | layerDone pulse, last busy cycle

  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int ACC_W  = PROD_W + $clog2(N_INPUTS);
  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam int ACT_CW = $clog2(FRAC_W + 1);
  localparam logic [ACC_W-1:0] MAX_MAG = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_SAT, S_ACT, S_DONE} state_t;

  state_t                      r_state;
  logic signed [WEIGHT_W-1:0]  r_w [N_INPUTS];
  logic signed [DATA_W-1:0]    r_in [N_INPUTS];
  logic                        r_sel;
  logic [CNT_W-1:0]            r_idx;
  logic signed [PROD_W-1:0]    r_prod;
  logic signed [ACC_W-1:0]     r_acc;
  logic [DATA_W-1:0]           r_rem;
  logic [DATA_W-1:0]           r_den;
  logic [FRAC_W:0]             r_nbits;
  logic [FRAC_W-1:0]           r_q;
  logic                        r_neg;
  logic [ACT_CW-1:0]           r_cnt;
  logic [DATA_W-1:0]           r_out;
  logic                        r_done;
  logic                        r_busy;

  logic signed [DATA_W-1:0]    w_in_sel;
  logic signed [WEIGHT_W-1:0]  w_w_sel;
  logic signed [PROD_W-1:0]    w_prod;
  logic                        w_sign;
  logic [ACC_W-1:0]            w_abs_acc;
  logic [DATA_W-2:0]           w_mag;
  logic [DATA_W-1:0]           w_clamp;
  logic [DATA_W:0]             w_trial;
  logic [DATA_W:0]             w_diff;
  logic                        w_ge;
  logic [FRAC_W:0]             w_q_next;
  logic [DATA_W-1:0]           w_q_ext;
  logic [DATA_W-1:0]           w_elliot;

  always_comb begin
    w_in_sel = '0;
    w_w_sel  = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (r_idx == CNT_W'(i)) begin
        w_in_sel = r_in[i];
        w_w_sel  = r_w[i];
      end
    end
  end

  assign w_prod = PROD_W'(w_in_sel) * PROD_W'(w_w_sel);

  // Clamp via magnitude so the most negative code can never appear.
  assign w_sign    = r_acc[ACC_W-1];
  assign w_abs_acc = w_sign ? -r_acc : r_acc;
  assign w_mag     = (w_abs_acc > MAX_MAG) ? {(DATA_W-1){1'b1}} : w_abs_acc[DATA_W-2:0];
  assign w_clamp   = w_sign ? -{1'b0, w_mag} : {1'b0, w_mag};

  // Borrow bit of the trial subtraction doubles as the compare result.
  assign w_trial  = {r_rem, r_nbits[FRAC_W]};
  assign w_diff   = w_trial - {1'b0, r_den};
  assign w_ge     = ~w_diff[DATA_W];
  assign w_q_next = {r_q, w_ge};
  assign w_q_ext  = {{(DATA_W-FRAC_W-1){1'b0}}, w_q_next};
  assign w_elliot = r_neg ? -w_q_ext : w_q_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      for (int i = 0; i < N_INPUTS; i++) begin
        r_w[i]  <= '0;
        r_in[i] <= '0;
      end
      r_sel   <= 1'b0;
      r_idx   <= '0;
      r_prod  <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_den   <= '0;
      r_nbits <= '0;
      r_q     <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (write && (int'(address) < N_INPUTS)) r_w[address] <= weight;
          if (sumTrigger) begin
            for (int i = 0; i < N_INPUTS; i++) r_in[i] <= inputs[i*DATA_W +: DATA_W];
            r_sel   <= layer_Sel;
            r_acc   <= '0;
            r_prod  <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc  <= r_acc + ACC_W'(r_prod);
          r_prod <= w_prod;
          if (r_idx == CNT_W'(N_INPUTS)) r_state <= S_SAT;
          else                           r_idx   <= r_idx + CNT_W'(1);
        end
        S_SAT: begin
          if (!r_sel) begin
            r_out   <= w_clamp;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_rem   <= {2'b00, w_mag[DATA_W-2:1]};
            r_nbits <= {w_mag[0], {FRAC_W{1'b0}}};
            r_den   <= DATA_W'(2**FRAC_W) + {1'b0, w_mag};
            r_q     <= '0;
            r_neg   <= w_sign;
            r_cnt   <= ACT_CW'(FRAC_W);
            r_state <= S_ACT;
          end
        end
        S_ACT: begin
          r_rem   <= w_ge ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
          r_nbits <= {r_nbits[FRAC_W-1:0], 1'b0};
          r_q     <= w_q_next[FRAC_W-1:0];
          if (r_cnt == '0) begin
            r_out   <= w_elliot;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - ACT_CW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign layerOut  = r_out;
  assign layerDone = r_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_neural_unit_seq.sv
// Self-checking bench for neural_unit_seq: table vectors, randomized runs against an
// arithmetic reference model, and hand sequences for busy protection, reset and same-edge start.
module tb_neural_unit_seq;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FR = 8;
  localparam int WW = 8;
  localparam int LAT_LIN = N + 2;
  localparam int LAT_ACT = N + FR + 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*DW-1:0] in_bus;
  logic [WW-1:0]   weight;
  logic [1:0]      address;
  logic            write, sumTrigger, layer_Sel;
  logic [DW-1:0]   layerOut;
  logic            layerDone, busy;

  int checks = 0;
  int errors = 0;
  int m_w [N];

  typedef struct packed {
    logic [3:0][7:0]  w;
    logic [3:0][31:0] x;
    logic             sel;
    logic [31:0]      exp;
  } vec_t;
  vec_t tbl [8];

  neural_unit_seq dut (
    .clk(clk), .reset(reset), .inputs(in_bus), .weight(weight), .address(address),
    .write(write), .sumTrigger(sumTrigger), .layer_Sel(layer_Sel),
    .layerOut(layerOut), .layerDone(layerDone), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [N*DW-1:0] bus, input logic sel);
    longint s = 0;
    longint lim = (longint'(1) << (DW-1)) - 1;
    longint a, q;
    for (int i = 0; i < N; i++) s += longint'($signed(bus[i*DW +: DW])) * longint'(m_w[i]);
    if (s > lim) s = lim;
    if (s < -lim) s = -lim;
    if (sel) begin
      a = (s < 0) ? -s : s;
      q = (a * (longint'(1) << FR)) / ((longint'(1) << FR) + a);
      s = (s < 0) ? -q : q;
    end
    return 32'(s);
  endfunction

  task automatic write_w(input int a, input logic [7:0] v);
    @(negedge clk);
    write = 1'b1; address = 2'(a); weight = v;
    @(posedge clk); #1;
    write = 1'b0;
    m_w[a] = int'($signed(v));
  endtask

  // Start on the next edge, then wait for layerDone with a bounded cycle budget.
  task automatic do_run(input string name, input logic [N*DW-1:0] bus, input logic sel,
                        input logic [31:0] exp);
    int lat = 0;
    bit seen = 0;
    bit moved = 0;
    logic [31:0] prev;
    @(negedge clk);
    prev = layerOut;
    in_bus = bus; layer_Sel = sel; sumTrigger = 1'b1;
    @(posedge clk); #1;
    sumTrigger = 1'b0; write = 1'b0;
    chk({name, "_busy_start"}, 64'(busy), 64'd1);
    while (!seen && lat < 40) begin
      if (layerOut !== prev) moved = 1;
      @(posedge clk); #1;
      lat++;
      if (layerDone) seen = 1;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_latency"}, 64'(lat), 64'(sel ? LAT_ACT : LAT_LIN));
    chk({name, "_out"}, 64'(layerOut), 64'(exp));
    chk({name, "_out_stable"}, 64'(moved), 64'd0);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 64'(layerDone), 64'd0);
    chk({name, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [N*DW-1:0] bus;
    logic            sel;
    int              pulses;

    reset = 1'b1; in_bus = '0; weight = '0; address = '0;
    write = 0; sumTrigger = 0; layer_Sel = 0;
    for (int i = 0; i < N; i++) m_w[i] = 0;

    tbl[0] = '{w: {8'd3, 8'd2, 8'd1, 8'd0}, x: {32'd3, 32'd2, 32'd1, 32'd0}, sel: 1'b0, exp: 32'd14};
    tbl[1] = '{w: {8'd0, 8'd0, 8'd0, 8'd1}, x: {32'd9, 32'd9, 32'd9, 32'd256}, sel: 1'b1, exp: 32'd128};
    tbl[2] = '{w: {8'd0, 8'd0, 8'd0, 8'd1}, x: {32'd0, 32'd0, 32'd0, 32'hFFFFFF00}, sel: 1'b1, exp: 32'hFFFFFF80};
    tbl[3] = '{w: {8'd0, 8'd0, 8'd0, 8'd127}, x: {32'd5, 32'd5, 32'd5, 32'h7FFFFFFF}, sel: 1'b0, exp: 32'h7FFFFFFF};
    tbl[4] = '{w: {8'd0, 8'd0, 8'd0, 8'd1}, x: {32'd0, 32'd0, 32'd0, 32'h80000000}, sel: 1'b0, exp: 32'h80000001};
    tbl[5] = '{w: {8'd0, 8'd0, 8'd0, 8'd1}, x: {32'd0, 32'd0, 32'd0, 32'h7FFFFFFF}, sel: 1'b1, exp: 32'd255};
    tbl[6] = '{w: {8'h80, 8'h80, 8'h80, 8'h80}, x: {4{32'h7FFFFFFF}}, sel: 1'b1, exp: 32'hFFFFFF01};
    tbl[7] = '{w: {8'd0, 8'd0, 8'hFF, 8'd2}, x: {32'd0, 32'd0, 32'd50, 32'd100}, sel: 1'b1, exp: 32'd94};

    repeat (3) @(negedge clk);
    chk("rst_out", 64'(layerOut), 64'd0);
    chk("rst_done", 64'(layerDone), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    do_run("rst_weights", {32'd11, 32'd22, 32'd33, 32'd44}, 1'b0, 32'd0);

    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < N; j++) write_w(j, tbl[k].w[j]);
      do_run($sformatf("vec%0d", k), tbl[k].x, tbl[k].sel, tbl[k].exp);
    end

    for (int r = 0; r < 24; r++) begin
      for (int j = 0; j < N; j++) write_w(j, 8'($urandom_range(0, 255)));
      for (int j = 0; j < N; j++)
        bus[j*DW +: DW] = (r % 2 == 0) ? 32'($signed(17'($urandom_range(0, 131071)))) : $urandom();
      sel = 1'($urandom_range(0, 1));
      do_run($sformatf("rand%0d", r), bus, sel, model(bus, sel));
    end

    // Writes and a second start while busy must both be ignored.
    write_w(0, 8'd7); write_w(1, 8'd0); write_w(2, 8'd0); write_w(3, 8'd0);
    @(negedge clk);
    in_bus = {32'd0, 32'd0, 32'd0, 32'd10}; layer_Sel = 0; sumTrigger = 1;
    @(negedge clk);
    sumTrigger = 1; write = 1; address = 2'd0; weight = 8'd5;
    @(negedge clk);
    sumTrigger = 0; write = 0;
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (layerDone) pulses++;
    end
    chk("busy_one_done", 64'(pulses), 64'd1);
    chk("busy_out", 64'(layerOut), 64'd70);
    do_run("busy_readback", {32'd0, 32'd0, 32'd0, 32'd1}, 1'b0, 32'd7);

    // Reset while the divider is running.
    write_w(0, 8'd1);
    @(negedge clk);
    in_bus = {32'd0, 32'd0, 32'd0, 32'd256}; layer_Sel = 1; sumTrigger = 1;
    @(posedge clk); #1;
    sumTrigger = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_out", 64'(layerOut), 64'd0);
    chk("midrst_done", 64'(layerDone), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) m_w[i] = 0;
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (layerDone) pulses++;
    end
    chk("midrst_no_done", 64'(pulses), 64'd0);
    bus = {32'd1000, 32'd2000, 32'd3000, 32'd4000};
    do_run("midrst_weights", bus, 1'b0, model(bus, 1'b0));

    // Write and start on the same edge: the new weight is used.
    write = 1; address = 2'd0; weight = 8'd2;
    m_w[0] = 2;
    do_run("same_edge", {32'd5, 32'd5, 32'd5, 32'd10}, 1'b0, 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
